regfile_write_queue: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/wq_bypass_match.sv | 35 +++
 rtl/regfile_write_queue.sv | 112 +++++++++++
 tb/tb_regfile_write_queue.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the writeback queue.
// Write entries are {addr, data}; register 0 is hardwired to zero.
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/wq_bypass_match.sv
// Youngest-match lookup over the pending-write ring.
// Entries from head for count slots are live; the last live hit wins.
module wq_bypass_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  wr_entry_t               ents [DEPTH],
   input  logic [PTR_W-1:0]        head,
   input  logic [CNT_W-1:0]        count,
   input  logic [REG_ADDR_W-1:0]   raddr,
   output logic                    hit,
   output logic [REG_DATA_W-1:0]   data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = head;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) &&
             (ents[idx].addr == raddr)) begin
            hit  = 1'b1;
            data = ents[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_write_queue.sv
// In-order pending-write buffer in front of register_file, draining
// one entry per cycle, with youngest-entry bypass on both read ports.
module regfile_write_queue
   import regfile_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              rf_hold,
   output logic              WrEn,
   output logic [ADDR_W-1:0] Aw,
   output logic [DATA_W-1:0] Dw,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] rf_Da,
   input  logic [DATA_W-1:0] rf_Db,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [CNT_W-1:0]  pending
);

   wr_entry_t        ents_q [DEPTH];
   logic [PTR_W-1:0] head_q;
   logic [PTR_W-1:0] tail_q;
   logic [CNT_W-1:0] count_q;

   logic             nonempty;
   logic             accept;
   logic             enq;
   logic             hit_a;
   logic             hit_b;
   logic [DATA_W-1:0] byp_a;
   logic [DATA_W-1:0] byp_b;

   assign nonempty = (count_q != '0);
   assign wb_ready = (count_q != CNT_W'(DEPTH));
   assign accept   = wb_valid && wb_ready;
   assign enq      = accept && (wb_addr != ZERO_REG);
   assign WrEn     = nonempty && !rf_hold;
   assign pending  = count_q;

   assign Aw = nonempty ? ents_q[head_q].addr : '0;
   assign Dw = nonempty ? ents_q[head_q].data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (WrEn)
            head_q <= head_q + PTR_W'(1);
         if (enq)
            tail_q <= tail_q + PTR_W'(1);
         unique case ({enq, WrEn})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; liveness comes from head and count.
   always_ff @(posedge clk) begin
      if (enq)
         ents_q[tail_q] <= '{addr: wb_addr, data: wb_data};
   end

   wq_bypass_match #(.DEPTH(DEPTH)) u_match_a (
      .ents  (ents_q),
      .head  (head_q),
      .count (count_q),
      .raddr (rd_addr_a),
      .hit   (hit_a),
      .data  (byp_a)
   );

   wq_bypass_match #(.DEPTH(DEPTH)) u_match_b (
      .ents  (ents_q),
      .head  (head_q),
      .count (count_q),
      .raddr (rd_addr_b),
      .hit   (hit_b),
      .data  (byp_b)
   );

   always_comb begin
      rd_data_a = rf_Da;
      if (rd_addr_a == ZERO_REG)
         rd_data_a = '0;
      else if (hit_a)
         rd_data_a = byp_a;
   end

   always_comb begin
      rd_data_b = rf_Db;
      if (rd_addr_b == ZERO_REG)
         rd_data_b = '0;
      else if (hit_b)
         rd_data_b = byp_b;
   end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Bench for regfile_write_queue: vector table, corner sequences and
// random traffic against a queue-based model with its own register file.
module tb_regfile_write_queue;
   import regfile_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        rf_hold;
   logic        WrEn;
   logic [4:0]  Aw;
   logic [31:0] Dw;
   logic [4:0]  rd_addr_a;
   logic [4:0]  rd_addr_b;
   logic [31:0] rf_Da;
   logic [31:0] rf_Db;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic [2:0]  pending;

   logic        rf_init;
   logic [31:0] rf [32];
   logic [31:0] exp_rf [32];
   wr_entry_t   mq [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic        v;
      logic [4:0]  a;
      logic [31:0] d;
      logic        h;
      logic [4:0]  ra;
      logic        rdy;
      int          pend;
      logic        we;
      logic [4:0]  aw;
      logic [31:0] dw;
      logic [31:0] rda;
   } vec_t;

   vec_t vt [17];

   always #5 clk = ~clk;

   regfile_write_queue #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rf_hold   (rf_hold),
      .WrEn      (WrEn),
      .Aw        (Aw),
      .Dw        (Dw),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rf_Da     (rf_Da),
      .rf_Db     (rf_Db),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .pending   (pending)
   );

   // register_file stand-in
   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= 32'h100 + i;
      end else if (WrEn) begin
         rf[Aw] <= Dw;
      end
   end

   assign rf_Da = rf[rd_addr_a];
   assign rf_Db = rf[rd_addr_b];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] byp(input logic [4:0] ra);
      logic [31:0] r;
      if (ra == 5'd0)
         return 32'd0;
      r = exp_rf[ra];
      foreach (mq[i])
         if (mq[i].addr == ra)
            r = mq[i].data;
      return r;
   endfunction

   task automatic mchk();
      chk("m_ready", {31'd0, wb_ready}, {31'd0, mq.size() < DEPTH});
      chk("m_pending", {29'd0, pending}, mq.size());
      chk("m_wren", {31'd0, WrEn},
          {31'd0, (mq.size() != 0) && !rf_hold});
      chk("m_aw", {27'd0, Aw}, (mq.size() != 0) ? {27'd0, mq[0].addr} : 0);
      chk("m_dw", Dw, (mq.size() != 0) ? mq[0].data : 32'd0);
      chk("m_rda", rd_data_a, byp(rd_addr_a));
      chk("m_rdb", rd_data_b, byp(rd_addr_b));
   endtask

   // Advance the model across one rising edge using pre-edge inputs.
   task automatic step();
      logic we;
      logic acc;
      we  = (mq.size() != 0) && !rf_hold;
      acc = wb_valid && (mq.size() < DEPTH);
      @(posedge clk);
      #1;
      if (we) begin
         exp_rf[mq[0].addr] = mq[0].data;
         mq.delete(0);
      end
      if (acc && wb_addr != 5'd0)
         mq.push_back('{addr: wb_addr, data: wb_data});
   endtask

   task automatic cyc();
      @(negedge clk);
      mchk();
      step();
   endtask

   task automatic drive(input logic v, input logic [4:0] a,
                        input logic [31:0] d, input logic h,
                        input logic [4:0] ra, input logic [4:0] rb);
      wb_valid  = v;
      wb_addr   = a;
      wb_data   = d;
      rf_hold   = h;
      rd_addr_a = ra;
      rd_addr_b = rb;
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      rst_n   = 1'b0;
      rf_init = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, wb_ready}, 32'd1);
      chk("rst_pending", {29'd0, pending}, 32'd0);
      chk("rst_wren", {31'd0, WrEn}, 32'd0);
      rf_init = 1'b0;
      rst_n   = 1'b1;
      mq.delete();
      for (int i = 0; i < 32; i++)
         exp_rf[i] = 32'h100 + i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int   first;
      int   last;
      int   n_acc;
      logic acc;

      vt[0]  = '{1, 4, 69, 0, 4, 1, 0, 0, 0, 0, 32'h104};
      vt[1]  = '{0, 0, 0, 0, 4, 1, 1, 1, 4, 69, 69};
      vt[2]  = '{0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 69};
      vt[3]  = '{1, 0, 69, 0, 0, 1, 0, 0, 0, 0, 0};
      vt[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      vt[5]  = '{1, 1, 17, 1, 1, 1, 0, 0, 0, 0, 32'h101};
      vt[6]  = '{1, 2, 18, 1, 1, 1, 1, 0, 1, 17, 17};
      vt[7]  = '{1, 3, 19, 1, 1, 1, 2, 0, 1, 17, 17};
      vt[8]  = '{1, 4, 20, 1, 1, 1, 3, 0, 1, 17, 17};
      vt[9]  = '{1, 5, 21, 1, 1, 0, 4, 0, 1, 17, 17};
      vt[10] = '{1, 5, 21, 1, 1, 0, 4, 0, 1, 17, 17};
      vt[11] = '{1, 5, 21, 0, 1, 0, 4, 1, 1, 17, 17};
      vt[12] = '{1, 5, 21, 0, 1, 1, 3, 1, 2, 18, 17};
      vt[13] = '{0, 0, 0, 0, 1, 1, 3, 1, 3, 19, 17};
      vt[14] = '{0, 0, 0, 0, 1, 1, 2, 1, 4, 20, 17};
      vt[15] = '{0, 0, 0, 0, 1, 1, 1, 1, 5, 21, 17};
      vt[16] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 17};

      do_reset();

      foreach (vt[i]) begin
         drive(vt[i].v, vt[i].a, vt[i].d, vt[i].h, vt[i].ra, vt[i].ra);
         @(negedge clk);
         chk($sformatf("v%0d_ready", i), {31'd0, wb_ready},
             {31'd0, vt[i].rdy});
         chk($sformatf("v%0d_pending", i), {29'd0, pending}, vt[i].pend);
         chk($sformatf("v%0d_wren", i), {31'd0, WrEn}, {31'd0, vt[i].we});
         chk($sformatf("v%0d_aw", i), {27'd0, Aw}, {27'd0, vt[i].aw});
         chk($sformatf("v%0d_dw", i), Dw, vt[i].dw);
         chk($sformatf("v%0d_rda", i), rd_data_a, vt[i].rda);
         mchk();
         step();
      end
      for (int a = 1; a <= 5; a++)
         chk("drain_rf", rf[a], 32'd16 + a);

      // youngest pending write to a register wins on both ports
      drive(1'b1, 5'd25, 32'd420, 1'b1, 5'd25, 5'd25);
      cyc();
      drive(1'b1, 5'd25, 32'd42, 1'b1, 5'd25, 5'd25);
      cyc();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 5'd25);
      @(negedge clk);
      chk("young_a", rd_data_a, 32'd42);
      chk("young_b", rd_data_b, 32'd42);
      chk("rf25_old", rf[25], 32'h119);
      mchk();
      step();
      rf_hold = 1'b0;
      repeat (3) cyc();
      chk("rf25_final", rf[25], 32'd42);

      // fill, then stream through a full queue
      for (int a = 6; a <= 9; a++) begin
         drive(1'b1, 5'(a), 32'h600 + a, 1'b1, 5'(a), 5'd6);
         cyc();
      end
      rf_hold  = 1'b0;
      n_acc    = 0;
      first    = -1;
      last     = -1;
      for (int c = 0; c < 40 && n_acc < 10; c++) begin
         wb_valid  = 1'b1;
         wb_addr   = 5'(10 + n_acc);
         wb_data   = 32'hA000 + n_acc;
         rd_addr_a = 5'(10 + n_acc);
         @(negedge clk);
         mchk();
         acc = wb_ready;
         step();
         if (acc) begin
            if (first < 0)
               first = c;
            last = c;
            n_acc++;
         end
      end
      chk("stream_cnt", n_acc, 10);
      chk("stream_rate", last - first + 1, 10);
      wb_valid = 1'b0;
      repeat (6) cyc();
      for (int a = 6; a <= 9; a++)
         chk("stream_pre", rf[a], 32'h600 + a);
      for (int k = 0; k < 10; k++)
         chk("stream_rf", rf[10 + k], 32'hA000 + k);

      // asynchronous reset with writes queued and drain about to start
      for (int a = 26; a <= 28; a++) begin
         drive(1'b1, 5'(a), 32'h2600 + a, 1'b1, 5'd26, 5'd28);
         cyc();
      end
      wb_valid = 1'b0;
      rf_hold  = 1'b0;
      #2;
      chk("pre_rst_wren", {31'd0, WrEn}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_wren", {31'd0, WrEn}, 32'd0);
      chk("arst_pending", {29'd0, pending}, 32'd0);
      chk("arst_ready", {31'd0, wb_ready}, 32'd1);
      chk("arst_rda", rd_data_a, 32'h100 + 26);
      chk("arst_rdb", rd_data_b, 32'h100 + 28);
      mq.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 26; a <= 28; a++)
         chk("arst_rf", rf[a], 32'h100 + a);

      // random traffic, heavy address reuse
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
               $urandom, ($urandom_range(0, 9) < 3),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cyc();
      end
      wb_valid = 1'b0;
      rf_hold  = 1'b0;
      repeat (DEPTH + 1) cyc();
      for (int a = 0; a < 8; a++)
         chk("rand_rf", rf[a], (a == 0) ? 32'h100 : exp_rf[a]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
